// File: rtl/sda_axi_read_arbiter.sv
// Round-robin arbiter merging NumPorts kernel-side AXI read ports onto one master port.
// The port index is carried in the upper ID bits so R beats can be routed back combinationally.
module sda_axi_read_arbiter #(
  parameter int NumPorts           = 2,
  parameter int AxiMasterAddrWidth = 64,
  parameter int AxiMasterDataWidth = 64,
  parameter int AxiMasterIdWidth   = 1,
  parameter int AxiMasterUserWidth = 1,
  parameter int MaxOutstanding     = 4,
  parameter int PortIdxWidth       = (NumPorts > 2) ? $clog2(NumPorts) : 1,
  localparam int AW = 29 + AxiMasterAddrWidth + AxiMasterIdWidth + AxiMasterUserWidth,
  localparam int DW = 3 + AxiMasterDataWidth + AxiMasterIdWidth + AxiMasterUserWidth
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NumPorts-1:0]        portArValid,
  input  logic [NumPorts*AW-1:0]     portArBus,
  output logic [NumPorts-1:0]        portArStop,
  output logic [NumPorts-1:0]        portRValid,
  output logic [NumPorts*DW-1:0]     portRBus,
  input  logic [NumPorts-1:0]        portRStop,
  output logic                       mArValid,
  output logic [AW+PortIdxWidth-1:0] mArBus,
  input  logic                       mArStop,
  input  logic                       mRValid,
  input  logic [DW+PortIdxWidth-1:0] mRBus,
  output logic                       mRStop,
  output logic                       errUnknownId
);

  // Every channel uses valid/stop: a beat transfers in a cycle with valid=1 and stop=0;
  // the sender keeps valid and the bus unchanged until that cycle.

  localparam int IW       = AxiMasterIdWidth;
  localparam int MAW      = AW + PortIdxWidth;
  localparam int MDW      = DW + PortIdxWidth;
  localparam int LastBit  = IW + PortIdxWidth + AxiMasterDataWidth + 2;
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0]     MaxCnt    = CntWidth'(MaxOutstanding);
  localparam logic [PortIdxWidth:0]   NumPortsW = (PortIdxWidth + 1)'(NumPorts);
  localparam logic [PortIdxWidth-1:0] LastPort  = PortIdxWidth'(NumPorts - 1);

  logic                    ar_valid_q;
  logic [MAW-1:0]          ar_bus_q;
  logic [PortIdxWidth-1:0] rr_last_q;
  logic [CntWidth-1:0]     outstanding_q [NumPorts];
  logic                    err_q;

  logic [NumPorts-1:0]     eligible;
  logic [NumPorts-1:0]     grant_oh;
  logic                    grant_any;
  logic [PortIdxWidth-1:0] grant_idx;
  logic [AW-1:0]           sel_port_bus;
  logic [MAW-1:0]          sel_bus;
  logic                    load_en;
  logic                    ar_load;

  logic [PortIdxWidth-1:0] r_idx;
  logic                    r_idx_ok;
  logic                    r_last;
  logic                    r_fire;
  logic [DW-1:0]           r_strip;

  // ---------------------------------------------------------------- AR arbitration
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumPorts; i++) begin
      eligible[i] = portArValid[i] && (outstanding_q[i] < MaxCnt);
    end
  end

  // Search begins one past the last granted port, so a port that just won has lowest priority.
  always_comb begin
    int                      cand;
    logic [PortIdxWidth-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      cand     = (int'(rr_last_q) + k) % NumPorts;
      cand_idx = PortIdxWidth'(cand);
      if (!grant_any && eligible[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    grant_oh     = '0;
    sel_port_bus = '0;
    for (int i = 0; i < NumPorts; i++) begin
      grant_oh[i] = grant_any && (grant_idx == PortIdxWidth'(i));
      if (grant_oh[i]) begin
        sel_port_bus = portArBus[i*AW +: AW];
      end
    end
  end

  assign sel_bus = {sel_port_bus[AW-1:IW], grant_idx, sel_port_bus[IW-1:0]};

  assign load_en    = !ar_valid_q || !mArStop;
  assign ar_load    = ap_rst_n && load_en && grant_any;
  assign portArStop = ~(grant_oh & {NumPorts{ar_load}});

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ar_valid_q <= 1'b0;
      rr_last_q  <= LastPort;
    end else if (load_en) begin
      ar_valid_q <= grant_any;
      if (grant_any) begin
        ar_bus_q  <= sel_bus;
        rr_last_q <= grant_idx;
      end
    end
  end

  assign mArValid = ar_valid_q;
  assign mArBus   = ar_bus_q;

  // ---------------------------------------------------------------- R routing
  assign r_idx    = mRBus[IW +: PortIdxWidth];
  assign r_idx_ok = {1'b0, r_idx} < NumPortsW;
  assign r_last   = mRBus[LastBit];
  assign r_strip  = {mRBus[MDW-1:IW+PortIdxWidth], mRBus[IW-1:0]};
  assign portRBus = {NumPorts{r_strip}};

  // An out-of-range index matches no port, leaving mRStop=0 so the beat is dropped.
  always_comb begin
    portRValid = '0;
    mRStop     = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (r_idx == PortIdxWidth'(i)) begin
        portRValid[i] = mRValid;
        mRStop        = portRStop[i];
      end
    end
  end

  assign r_fire = mRValid && !mRStop;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      err_q <= 1'b0;
    end else if (mRValid && !r_idx_ok) begin
      err_q <= 1'b1;
    end
  end

  assign errUnknownId = err_q;

  // ---------------------------------------------------------------- outstanding bursts
  for (genvar g = 0; g < NumPorts; g++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = ar_load && grant_oh[g];
    assign dec = r_fire && r_last && (r_idx == PortIdxWidth'(g));

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        outstanding_q[g] <= '0;
      end else if (inc && !dec) begin
        if (outstanding_q[g] != MaxCnt) begin
          outstanding_q[g] <= outstanding_q[g] + CntWidth'(1);
        end
      end else if (dec && !inc) begin
        if (outstanding_q[g] != '0) begin
          outstanding_q[g] <= outstanding_q[g] - CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: doc/sda_axi_read_arbiter.md
SDA_AXI_READ_ARBITER -- requirements
Module: sda_axi_read_arbiter

Interface
REQ-001 SHALL take parameter NumPorts, default 2: number of kernel-side read ports, legal 2..8.
REQ-002 SHALL take parameter AxiMasterAddrWidth, default 64: address width.
REQ-003 SHALL take parameter AxiMasterDataWidth, default 64: data width.
REQ-004 SHALL take parameter AxiMasterIdWidth, default 1: port-side ID width.
REQ-005 SHALL take parameter AxiMasterUserWidth, default 1: user width.
REQ-006 SHALL take parameter MaxOutstanding, default 4: per-port outstanding burst limit, legal 1..15.
REQ-007 SHALL take derived parameter PortIdxWidth = max(1, ceil(log2(NumPorts))).
REQ-008 SHALL use these derived widths:
- AW = 29+AxiMasterAddrWidth+AxiMasterIdWidth+AxiMasterUserWidth
- DW = 3+AxiMasterDataWidth+AxiMasterIdWidth+AxiMasterUserWidth
- AW+PortIdxWidth and DW+PortIdxWidth on the master side.
REQ-009 ap_clk  in  1  sole clock, rising edge.
REQ-010 ap_rst_n  in  1  reset: one clock; reset is synchronous and active-low.
REQ-011 portArValid  in  NumPorts  per-port read-address valid.
REQ-012 portArBus  in  NumPorts*AW  read-address buses; port i occupies slice i.
REQ-013 portArStop  out  NumPorts  per-port read-address stop.
REQ-014 portRValid  out  NumPorts  per-port read-data valid.
REQ-015 portRBus  out  NumPorts*DW  read-data buses; every slice carries the same data, with the port index stripped from the ID.
REQ-016 portRStop  in  NumPorts  per-port read-data stop.
REQ-017 mArValid, mArBus (AW+PortIdxWidth), mArStop: master read-address channel (out, out, in).
REQ-018 mRValid, mRBus (DW+PortIdxWidth), mRStop: master read-data channel (in, in, out).
REQ-019 errUnknownId  out  1  sticky flag; set when a response carries a port index >= NumPorts.
REQ-020 SHALL order bus fields MSB to LSB as {user, qos, region, prot, cache, lock, burst, size, len, addr, id} for address buses and {user, last, resp, data, id} for data buses.

Function
REQ-021 SHALL complete a transfer on any channel in a cycle where valid=1 and stop=0; a sender holds valid and bus stable until that cycle.
REQ-022 SHALL treat port i as eligible when portArValid[i]=1 and outstanding[i] < MaxOutstanding.
REQ-023 SHALL register mArValid/mArBus in one output stage that loads when empty or when its current contents transfer in the same cycle, giving a one-cycle minimum AR latency.
REQ-024 SHALL grant one eligible port per load, round-robin: search starts at last granted port + 1, wrapping from NumPorts-1 to 0.
REQ-025 SHALL assert portArStop[i]=0 only in the cycle port i is granted and loaded; all other ports see stop=1.
REQ-026 SHALL form the master ID as {i[PortIdxWidth-1:0], portId} in the ID field and pass all other fields unchanged.
REQ-027 SHALL increment outstanding[i] on port i AR acceptance and decrement it on an R transfer with last=1 routed to port i; simultaneous increment and decrement leave it unchanged.
REQ-028 SHALL route R combinationally by the ID upper bits idx: portRValid[idx]=mRValid, all other portRValid=0, mRStop=portRStop[idx].
REQ-029 SHALL consume R beats with idx >= NumPorts (mRStop=0), present them to no port, and set errUnknownId until reset.
REQ-030 SHALL never let outstanding[i] exceed MaxOutstanding or underflow below 0; a decrement at 0 is ignored.
REQ-031 SHALL grant no port in a cycle where none is eligible; the output stage empties normally.

Reset
REQ-032 SHALL, while ap_rst_n=0 at a rising edge, clear mArValid, all outstanding counters, the round-robin pointer (port 0 highest priority next) and errUnknownId.
REQ-033 SHALL hold portArStop at all ones during reset; the R path stays combinational.
REQ-034 SHALL discard an address held in the output stage when reset is asserted mid-operation; it is not re-issued.

Verification
REQ-035 Ports 0 and 1 both valid continuously, mArStop=0 -> grants alternate 0,1,0,1; mArBus ID upper bit alternates 0/1; first mArValid one cycle after the first valid.
REQ-036 MaxOutstanding=2, port 0 issues 3 ARs with no R returned -> third held (portArStop[0]=1); one rlast beat to idx 0 -> third accepted the next cycle.
REQ-037 mArStop=1 for 5 cycles with a loaded request -> mArBus stable, no further port accepted; release -> transfer, next grant loads the same cycle.
REQ-038 R beat with ID {1, 0} and portRStop[1]=1 -> mRStop=1, portRValid=2'b10; portRStop[1]=0 -> beat completes, portRBus ID=0.
REQ-039 NumPorts=3, R beat with idx=3 -> mRStop=0, no portRValid, errUnknownId=1 until ap_rst_n=0.
REQ-040 Reset asserted with mArValid=1 and counters nonzero -> next cycle mArValid=0, counters 0; a port-1 request after reset is accepted after port 0 priority is applied.
